// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply or restoring divide,
// with a fast path for divide-by-zero and signed overflow, and abort on pipeline flush.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_m,
    input  logic        is_d,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        fin,
    output logic        busy,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic [1:0]  op_q, op_d;
    logic        is_div_q, is_div_d;
    logic [31:0] result_q, result_d;

    // Operand decode for a request presented in IDLE.
    logic        sgn_a, sgn_b, neg_a_in, neg_b_in, div_zero, div_ovf;
    logic [31:0] mag_a, mag_b, special_res;

    always_comb begin
        sgn_a       = is_d ? ~op[0] : (op != 2'b11);
        sgn_b       = is_d ? ~op[0] : ~op[1];
        neg_a_in    = sgn_a & src_a[31];
        neg_b_in    = sgn_b & src_b[31];
        mag_a       = neg_a_in ? -src_a : src_a;
        mag_b       = neg_b_in ? -src_b : src_b;
        div_zero    = (src_b == 32'h0);
        div_ovf     = ~op[0] & (src_a == 32'h8000_0000) & (src_b == 32'hFFFF_FFFF);
        special_res = div_zero ? (op[1] ? src_a : 32'hFFFF_FFFF)
                               : (op[1] ? 32'h0 : 32'h8000_0000);
    end

    // One iteration: accumulator is {quotient, remainder} while dividing.
    logic [63:0] mul_add, mul_acc, div_acc, prod;
    logic [32:0] div_shift, div_diff;
    logic [31:0] quo, rem, sign_res;

    always_comb begin
        mul_add   = {32'h0, a_q} << cnt_q;
        mul_acc   = b_q[cnt_q] ? acc_q + mul_add : acc_q;
        div_shift = {acc_q[31:0], a_q[5'd31 - cnt_q]};
        div_diff  = div_shift - {1'b0, b_q};
        div_acc   = {acc_q[62:32], ~div_diff[32],
                     div_diff[32] ? div_shift[31:0] : div_diff[31:0]};
        prod      = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo       = acc_q[63:32];
        rem       = acc_q[31:0];
        if (!is_div_q)
            sign_res = (op_q == 2'b00) ? prod[31:0] : prod[63:32];
        else if (op_q[1])
            sign_res = neg_a_q ? -rem : rem;
        else
            sign_res = (neg_a_q ^ neg_b_q) ? -quo : quo;
    end

    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        op_d     = op_q;
        is_div_d = is_div_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if ((is_m | is_d) & ~flush) begin
                    op_d     = op;
                    is_div_d = is_d;
                    if (is_d & (div_zero | div_ovf)) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        a_d     = mag_a;
                        b_d     = mag_b;
                        neg_a_d = neg_a_in;
                        neg_b_d = neg_b_in;
                        acc_d   = 64'h0;
                        cnt_d   = 5'd0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = is_div_q ? div_acc : mul_acc;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = SIGN;
                end
            end
            SIGN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    result_d = sign_res;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            acc_q    <= 64'h0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            op_q     <= 2'b00;
            is_div_q <= 1'b0;
            result_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            op_q     <= op_d;
            is_div_q <= is_div_d;
            result_q <= result_d;
        end
    end

    assign fin    = (state_q == DONE);
    assign busy   = (state_q != IDLE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table plus hand-written
// flush, reset and back-to-back sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_m, is_d, flush;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        fin, busy;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .is_m(is_m), .is_d(is_d), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .fin(fin), .busy(busy), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        m;
        logic        d;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic m, input logic d, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b, output int t0);
        @(negedge clk);
        is_m = m; is_d = d; op = o; src_a = a; src_b = b;
        t0 = cyc;
        @(negedge clk);
        is_m = 1'b0; is_d = 1'b0;
        op = 2'($urandom_range(3));
        src_a = $urandom; src_b = $urandom;
    endtask

    task automatic wait_fin(output int at, output int busy_cnt);
        at = -1;
        busy_cnt = 0;
        for (int k = 0; k < 60 && at < 0; k++) begin
            busy_cnt += int'(busy);
            if (fin) at = cyc;
            else @(negedge clk);
        end
    endtask

    initial begin
        int t0, at, bc, f1, f2;
        logic saw_fin;

        vecs[0]  = '{1'b1, 1'b0, 2'b00, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{1'b1, 1'b0, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
        vecs[2]  = '{1'b1, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[3]  = '{1'b1, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34};
        vecs[4]  = '{1'b1, 1'b0, 2'b11, 32'h8000_0000, 32'd4,         32'h0000_0002, 34};
        vecs[5]  = '{1'b1, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34};
        vecs[6]  = '{1'b0, 1'b1, 2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
        vecs[7]  = '{1'b0, 1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
        vecs[8]  = '{1'b0, 1'b1, 2'b01, 32'd100,        32'd7,         32'd14,        34};
        vecs[9]  = '{1'b0, 1'b1, 2'b00, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 34};
        vecs[10] = '{1'b0, 1'b1, 2'b10, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 34};
        vecs[11] = '{1'b0, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34};
        vecs[12] = '{1'b0, 1'b1, 2'b00, 32'h8000_0000, 32'd1,         32'h8000_0000, 34};
        vecs[13] = '{1'b0, 1'b1, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34};
        vecs[14] = '{1'b0, 1'b1, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34};
        vecs[15] = '{1'b0, 1'b1, 2'b01, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[16] = '{1'b0, 1'b1, 2'b10, 32'd5,          32'd0,         32'd5,         1};
        vecs[17] = '{1'b0, 1'b1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[18] = '{1'b0, 1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        // Both request lines high: divide wins (REMU 100 % 7).
        vecs[19] = '{1'b1, 1'b1, 2'b11, 32'd100,        32'd7,         32'd2,         34};

        rst = 1'b1; is_m = 1'b0; is_d = 1'b0; flush = 1'b0;
        op = 2'b00; src_a = 32'h0; src_b = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_fin", {63'h0, fin}, 64'h0);
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_result", {32'h0, result}, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].m, vecs[i].d, vecs[i].o, vecs[i].a, vecs[i].b, t0);
            wait_fin(at, bc);
            check($sformatf("vec%0d_result", i), {32'h0, result}, {32'h0, vecs[i].exp});
            check($sformatf("vec%0d_latency", i), 64'(at - t0), 64'(vecs[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(vecs[i].lat));
            @(negedge clk);
            check($sformatf("vec%0d_fin_after", i), {63'h0, fin}, 64'h0);
            check($sformatf("vec%0d_busy_after", i), {63'h0, busy}, 64'h0);
        end

        // Request together with flush in IDLE is dropped.
        @(negedge clk);
        is_m = 1'b1; flush = 1'b1; src_a = 32'd3; src_b = 32'd3;
        @(negedge clk);
        is_m = 1'b0; flush = 1'b0;
        check("flush_req_busy", {63'h0, busy}, 64'h0);
        check("flush_req_fin", {63'h0, fin}, 64'h0);

        // Flush at T+10 of a DIV, then MUL at T+11.
        issue(1'b0, 1'b1, 2'b00, 32'd1000, 32'd3, t0);
        saw_fin = 1'b0;
        for (int k = 0; k < 20 && cyc < t0 + 10; k++) begin
            saw_fin |= fin;
            @(negedge clk);
        end
        saw_fin |= fin;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_cycle", 64'(cyc - t0), 64'd11);
        check("flush_busy", {63'h0, busy}, 64'h0);
        check("flush_fin", {63'h0, fin}, 64'h0);
        check("flush_result_kept", {32'h0, result}, {32'h0, vecs[NV-1].exp});
        is_m = 1'b1; op = 2'b00; src_a = 32'd1000; src_b = 32'd1000;
        @(negedge clk);
        is_m = 1'b0; src_a = $urandom; src_b = $urandom;
        for (int k = 0; k < 60 && !fin; k++) begin
            @(negedge clk);
        end
        check("flush_no_div_fin", {63'h0, saw_fin}, 64'h0);
        check("after_flush_mul_cycle", 64'(cyc - t0), 64'd45);
        check("after_flush_mul_result", {32'h0, result}, 64'h000F_4240);

        // Asynchronous reset in the middle of a MUL.
        issue(1'b1, 1'b0, 2'b00, 32'h1234, 32'h10, t0);
        for (int k = 0; k < 30 && cyc < t0 + 20; k++) @(negedge clk);
        check("pre_reset_busy", {63'h0, busy}, 64'h1);
        #1 rst = 1'b1;
        #1;
        check("async_reset_fin", {63'h0, fin}, 64'h0);
        check("async_reset_busy", {63'h0, busy}, 64'h0);
        check("async_reset_result", {32'h0, result}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back MULs: second request in the first IDLE cycle.
        issue(1'b1, 1'b0, 2'b00, 32'd3, 32'd5, t0);
        wait_fin(f1, bc);
        check("b2b_first_latency", 64'(f1 - t0), 64'd34);
        check("b2b_first_result", {32'h0, result}, 64'd15);
        issue(1'b1, 1'b0, 2'b00, 32'd6, 32'hFFFF_FFFF, t0);
        check("b2b_second_issue", 64'(t0 - f1), 64'd1);
        wait_fin(f2, bc);
        check("b2b_fin_spacing", 64'(f2 - f1), 64'd35);
        check("b2b_second_result", {32'h0, result}, 64'h0000_0000_FFFF_FFFA);
        @(negedge clk);
        check("b2b_fin_single", {63'h0, fin}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
